// File: rtl/rv_pkg.sv
// Shared RV32 encodings and MEM-stage state type.
package rv_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a memory word and extends it per funct3.
module load_align
  import rv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] data
);
  logic [31:0] sh;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    data = '0;
    case (funct3)
      F3_B:    data = {{24{sh[7]}}, sh[7:0]};
      F3_H:    data = {{16{sh[15]}}, sh[15:0]};
      F3_W:    data = rdata;
      F3_BU:   data = {24'h0, sh[7:0]};
      F3_HU:   data = {16'h0, sh[15:0]};
      default: data = '0;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// MEM stage: one load/store per instruction against a req/ack data memory.
// IDLE->REQ->DONE, at least 3 cycles; upstream stalled in IDLE(start) and REQ.
module mem_stage
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSN       = NOP
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_insn,
  input  logic [31:0] i_ALU_O,
  input  logic [31:0] i_rs2_D,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] o_insn,
  output logic [31:0] o_ALU_O,
  output logic [31:0] o_mem_D,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_bus_err
);
  localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

  state_t      state;
  logic [2:0]  funct3, f3_q;
  logic [1:0]  off, off_q;
  logic        is_store, mem_op, misaligned, start;
  logic [3:0]  st_mask;
  logic [31:0] st_data, aligned, load_q, cnt;
  logic        err_q;

  assign funct3     = i_insn[14:12];
  assign off        = i_ALU_O[1:0];
  assign is_store   = (i_insn[6:0] == OP_STORE);
  assign mem_op     = i_valid & ((i_insn[6:0] == OP_LOAD) | is_store);
  assign misaligned = ((funct3[1:0] == 2'b01) & off[0]) |
                      ((funct3[1:0] == 2'b10) & (off != 2'b00));

  assign o_misaligned = (state == IDLE) & mem_op & misaligned;
  assign start        = (state == IDLE) & mem_op & ~misaligned;
  assign o_insn       = o_misaligned ? NOP_INSN : i_insn;
  assign o_ALU_O      = i_ALU_O;
  assign o_stall      = start | (state == REQ);
  assign o_mem_D      = (state == DONE) ? load_q : '0;
  assign o_bus_err    = (state == DONE) & err_q;

  // Store data is replicated across lanes so the mask alone selects the bytes.
  always_comb begin
    st_mask = '0;
    st_data = i_rs2_D;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          st_mask = 4'b0001 << off;
          st_data = {4{i_rs2_D[7:0]}};
        end
        F3_H: begin
          st_mask = 4'b0011 << off;
          st_data = {2{i_rs2_D[15:0]}};
        end
        F3_W:    st_mask = 4'b1111;
        default: st_mask = '0;
      endcase
    end
  end

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .funct3 (f3_q),
    .off    (off_q),
    .data   (aligned)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wmask <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      cnt        <= '0;
      load_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state      <= REQ;
          dmem_req   <= 1'b1;
          dmem_we    <= is_store;
          dmem_addr  <= {i_ALU_O[31:2], 2'b00};
          dmem_wdata <= st_data;
          dmem_wmask <= st_mask;
          f3_q       <= funct3;
          off_q      <= off;
          cnt        <= '0;
          err_q      <= 1'b0;
        end
        REQ: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            load_q   <= dmem_we ? '0 : aligned;
            state    <= DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt == TO_LAST)) begin
            dmem_req <= 1'b0;
            load_q   <= '0;
            err_q    <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          err_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage of the 5-stage RISC-V core; sits between the X/M latch and the M/W latch.
- Performs loads and stores against a handshaked data memory.
- Handles byte lanes, store masks and load sign/zero extension.
- Stalls the upstream pipeline while an access is outstanding.
- Drives insn/ALU_O/mem_D into the M/W latch.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in REQ without dmem_ack before bus error; 0 disables timeout.
- NOP_INSN, 32'h00000013: instruction substituted on a misaligned access.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- i_valid  in  1  i_insn is a live instruction
- i_insn  in  32  instruction from X/M latch
- i_ALU_O  in  32  ALU result; effective address for load/store
- i_rs2_D  in  32  store data
- dmem_rdata  in  32  memory read word
- dmem_ack  in  1  access complete; rdata valid this cycle
- dmem_req  out  1  access request, registered
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address (i_ALU_O & ~3)
- dmem_wdata  out  32  lane-replicated store data
- dmem_wmask  out  4  byte enables
- o_insn  out  32  to M/W latch
- o_ALU_O  out  32  to M/W latch
- o_mem_D  out  32  formatted load data to M/W latch
- o_stall  out  1  hold PC and all upstream latches
- o_misaligned  out  1  misaligned access detected
- o_bus_err  out  1  access timed out

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, sampled on posedge clock; posedge clock is the only edge used.
- Reset values: state=IDLE; dmem_req, dmem_we, dmem_wdata, dmem_wmask, dmem_addr, timeout counter, load register all 0. Combinational outputs evaluate accordingly (o_stall=0, o_bus_err=0, o_mem_D=0).
- Decode:
  - mem_op = i_valid & (opcode==7'b0000011 load | 7'b0100011 store).
  - funct3 = insn[14:12]; off = i_ALU_O[1:0].
  - Misaligned: half access (funct3[1:0]==01) with off[0]=1, or word access (10) with off!=0.
- Non-memory or invalid instruction:
  - o_insn=i_insn, o_ALU_O=i_ALU_O, o_mem_D=0, o_stall=0.
  - No request issued.
- Misaligned mem_op in IDLE:
  - o_insn=NOP_INSN, o_misaligned=1 (combinational, same cycle), o_stall=0.
  - No request issued.
- States:
  - IDLE: if aligned mem_op, register addr, we, wmask, wdata and funct3/off; go to REQ. o_stall=1 this cycle.
  - REQ: dmem_req=1, o_stall=1, other dmem_* outputs held stable. On dmem_ack, register formatted rdata and go to DONE. If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 without ack, drop req, set load register=0, set error flag, go to DONE.
  - DONE: dmem_req=0, o_stall=0, o_mem_D=load register (stores: 0), o_bus_err=error flag. Next state IDLE; error flag cleared on leaving DONE.
- Pass-through: o_insn=i_insn and o_ALU_O=i_ALU_O in every state except the misaligned case. The instruction is held upstream by o_stall.
- Latency: IDLE→REQ→DONE minimum 3 cycles; o_stall high for 2 cycles minimum.
- dmem_ack outside REQ is ignored.
- Store mask and data:
  - SB: wmask=4'b0001<<off, wdata={4{rs2[7:0]}}.
  - SH: wmask=4'b0011<<off, wdata={2{rs2[15:0]}}.
  - SW: wmask=4'b1111, wdata=rs2.
  - Loads: wmask=0.
- Load format: select byte rdata[8*off+:8] or half rdata[8*off+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW uses the full word.
  - Unsupported funct3 on a load (011, 110, 111) returns 0.
- Reset mid-operation (REQ or DONE): return to IDLE next edge, dmem_req drops, no result delivered.

Decomposition:
- Shared package rv_pkg holds opcode constants (OP_LOAD, OP_STORE), funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), the NOP encoding, and the state enum (IDLE/REQ/DONE).
- One combinational sub-module, load_align, maps (rdata, funct3, off) to the formatted 32-bit value.
- Store lane logic stays inline.

Test Plan:
- ADDI passes through (i_insn=32'h00500093, i_ALU_O=5) -> same-cycle o_insn/o_ALU_O unchanged, o_mem_D=0, o_stall=0, dmem_req never asserted.
- LB at addr 0x103, rdata=32'h80FF7F01, ack in first REQ cycle -> dmem_addr=0x100; DONE o_mem_D=32'hFFFFFF80; stall exactly 2 cycles; LBU same case -> 32'h00000080.
- SH at addr 0x202, rs2=32'h1234ABCD, ack delayed 3 cycles -> dmem_we=1, wmask=4'b1100, wdata=32'hABCDABCD held stable; o_stall high for 4 cycles.
- LW at addr 0x101 -> o_misaligned=1, o_insn=32'h00000013, no dmem_req, o_stall=0.
- LW with no ack, TIMEOUT_CYCLES=4 -> req high for 4 cycles then drops; DONE shows o_bus_err=1, o_mem_D=0; next instruction proceeds.
- reset asserted in second REQ cycle -> next edge dmem_req=0, state IDLE; a following ack pulse is ignored and o_mem_D stays 0.
